// File: rtl/cpu_pkg.sv
// Shared constants for the 5-stage MIPS core: widths, control-bundle bit positions, opcodes.
package cpu_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CTRL_W     = 8;

    // Control bundle layout {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], RegDst}
    localparam int unsigned CTRL_REGWRITE = 7;
    localparam int unsigned CTRL_MEMTOREG = 6;
    localparam int unsigned CTRL_MEMREAD  = 5;
    localparam int unsigned CTRL_MEMWRITE = 4;
    localparam int unsigned CTRL_ALUSRC   = 3;
    localparam int unsigned CTRL_ALUOP_HI = 2;
    localparam int unsigned CTRL_ALUOP_LO = 1;
    localparam int unsigned CTRL_REGDST   = 0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard: EX-stage load whose destination (rt) is read by the ID-stage instruction.
module load_use_detect #(
    parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    output logic                  hazard_c
);

    // $0 is hardwired to zero, so a load targeting it never creates a dependency
    always_comb begin
        hazard_c = ex_valid && ex_mem_read && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch/jump flush.
// Optional stall counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage #(
    parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
    parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int unsigned CTRL_W     = cpu_pkg::CTRL_W,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [CTRL_W-1:0]     ctrl_i,
    input  logic                  flush_i,
    input  logic [DATA_W-1:0]     rs_data_i,
    input  logic [DATA_W-1:0]     rt_data_i,
    input  logic [DATA_W-1:0]     imm_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rt_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    output logic [CTRL_W-1:0]     ctrl_o,
    output logic                  valid_o,
    output logic [DATA_W-1:0]     rs_data_o,
    output logic [DATA_W-1:0]     rt_data_o,
    output logic [DATA_W-1:0]     imm_o,
    output logic [REG_ADDR_W-1:0] rs_o,
    output logic [REG_ADDR_W-1:0] rt_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic                  hazard_o,
    output logic                  pc_write_o,
    output logic                  if_id_write_o
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt_o
`endif
);

    import cpu_pkg::*;

    logic [CTRL_W-1:0] ctrl_clean_c;
    logic              bubble_c;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .ex_valid    (valid_o),
        .ex_mem_read (ctrl_o[CTRL_MEMREAD]),
        .ex_rt       (rt_o),
        .id_rs       (rs_i),
        .id_rt       (rt_i),
        .hazard_c    (hazard_o)
    );

    // Unknown control bits from don't-care decode entries must enter EX as 0
    always_comb begin
        ctrl_clean_c = '0;
        for (int i = 0; i < int'(CTRL_W); i++) begin
            ctrl_clean_c[i] = (ctrl_i[i] === 1'b1);
        end
    end

    // Freeze follows the hazard only; a flush alone must let the branch target fetch proceed
    always_comb begin
        bubble_c      = hazard_o | flush_i;
        pc_write_o    = ~hazard_o;
        if_id_write_o = ~hazard_o;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_o    <= '0;
            valid_o   <= 1'b0;
            rs_data_o <= '0;
            rt_data_o <= '0;
            imm_o     <= '0;
            rs_o      <= '0;
            rt_o      <= '0;
            rd_o      <= '0;
        end else begin
            ctrl_o    <= bubble_c ? '0 : ctrl_clean_c;
            valid_o   <= ~bubble_c;
            rs_data_o <= rs_data_i;
            rt_data_o <= rt_data_i;
            imm_o     <= imm_i;
            rs_o      <= rs_i;
            rt_o      <= rt_i;
            rd_o      <= rd_i;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    // Saturating count of stall cycles
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (hazard_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/flush/scrub/reset steps plus random traffic.
module tb_id_ex_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 8;
    localparam int unsigned TB_CNT_W = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [CW-1:0] ctrl_i;
    logic          flush_i;
    logic [DW-1:0] rs_data_i, rt_data_i, imm_i;
    logic [AW-1:0] rs_i, rt_i, rd_i;
    logic [CW-1:0] ctrl_o;
    logic          valid_o;
    logic [DW-1:0] rs_data_o, rt_data_o, imm_o;
    logic [AW-1:0] rs_o, rt_o, rd_o;
    logic          hazard_o, pc_write_o, if_id_write_o;
`ifdef ID_EX_STALL_CNT_EN
    logic [TB_CNT_W-1:0] stall_cnt_o;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.CNT_W(TB_CNT_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .ctrl_i        (ctrl_i),
        .flush_i       (flush_i),
        .rs_data_i     (rs_data_i),
        .rt_data_i     (rt_data_i),
        .imm_i         (imm_i),
        .rs_i          (rs_i),
        .rt_i          (rt_i),
        .rd_i          (rd_i),
        .ctrl_o        (ctrl_o),
        .valid_o       (valid_o),
        .rs_data_o     (rs_data_o),
        .rt_data_o     (rt_data_o),
        .imm_o         (imm_o),
        .rs_o          (rs_o),
        .rt_o          (rt_o),
        .rd_o          (rd_o),
        .hazard_o      (hazard_o),
        .pc_write_o    (pc_write_o),
        .if_id_write_o (if_id_write_o)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    // Reference model: contents of the EX slot as an instruction record
    typedef struct {
        logic          valid;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] rsd, rtd, imm;
        logic [AW-1:0] rs, rt, rd;
    } slot_t;

    slot_t ex;
    int    cnt_m;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hazard();
        // A load in EX writes rt; a dependent read in ID must wait a cycle, except for $0
        return ex.valid && ex.ctrl[5] && (ex.rt != 0) && ((ex.rt == rs_i) || (ex.rt == rt_i));
    endfunction

    function automatic logic [CW-1:0] scrub(input logic [CW-1:0] c);
        logic [CW-1:0] r;
        for (int i = 0; i < int'(CW); i++) r[i] = (c[i] === 1'b1);
        return r;
    endfunction

    task automatic model_reset();
        ex = '{valid: 1'b0, ctrl: '0, rsd: '0, rtd: '0, imm: '0, rs: '0, rt: '0, rd: '0};
        cnt_m = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".ctrl"},  DW'(ctrl_o),  DW'(ex.ctrl));
        chk({tag, ".valid"}, DW'(valid_o), DW'(ex.valid));
        chk({tag, ".rsd"},   rs_data_o,    ex.rsd);
        chk({tag, ".rtd"},   rt_data_o,    ex.rtd);
        chk({tag, ".imm"},   imm_o,        ex.imm);
        chk({tag, ".rs"},    DW'(rs_o),    DW'(ex.rs));
        chk({tag, ".rt"},    DW'(rt_o),    DW'(ex.rt));
        chk({tag, ".rd"},    DW'(rd_o),    DW'(ex.rd));
`ifdef ID_EX_STALL_CNT_EN
        chk({tag, ".cnt"},   DW'(stall_cnt_o), DW'(cnt_m));
`endif
    endtask

    // Called at a falling edge with inputs already driven; checks hazard, clocks once, checks registers
    task automatic cycle(input string tag);
        logic h;
        logic bubble;
        #1;
        h = model_hazard();
        chk({tag, ".hazard"}, DW'(hazard_o),      DW'(h));
        chk({tag, ".pcw"},    DW'(pc_write_o),    DW'(!h));
        chk({tag, ".ifidw"},  DW'(if_id_write_o), DW'(!h));
        bubble = h || flush_i;
        if (h && cnt_m < 3) cnt_m++;
        ex.ctrl  = bubble ? '0 : scrub(ctrl_i);
        ex.valid = !bubble;
        ex.rsd = rs_data_i; ex.rtd = rt_data_i; ex.imm = imm_i;
        ex.rs = rs_i; ex.rt = rt_i; ex.rd = rd_i;
        @(posedge clk);
        @(negedge clk);
        check_regs(tag);
    endtask

    task automatic drive(input logic [CW-1:0] c, input logic fl,
                         input logic [AW-1:0] s, input logic [AW-1:0] t, input logic [AW-1:0] d);
        ctrl_i = c; flush_i = fl; rs_i = s; rt_i = t; rd_i = d;
        rs_data_i = $urandom; rt_data_i = $urandom; imm_i = $urandom;
    endtask

    task automatic drive_random();
        drive(CW'($urandom), 1'b0, AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
              AW'($urandom_range(0, 31)));
    endtask

    initial begin
        model_reset();
        rst_i = 1'b0;
        drive_random();

        // Reset held with random inputs across edges
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_random();
            #1;
            chk("rst.hazard", DW'(hazard_o),      DW'(0));
            chk("rst.pcw",    DW'(pc_write_o),    DW'(1));
            chk("rst.ifidw",  DW'(if_id_write_o), DW'(1));
            check_regs("rst");
        end

        // Release; first edge loads an R-type bundle
        @(negedge clk);
        rst_i = 1'b1;
        drive(8'b10000101, 1'b0, 5'd1, 5'd2, 5'd3);
        cycle("first");
        chk("first.ctrl_const", DW'(ctrl_o), DW'(8'h85));

        // Load-use: lw rt=5 then add rs=5
        drive(8'b11101000, 1'b0, 5'd9, 5'd5, 5'd0);
        cycle("lw5");
        drive(8'b10000101, 1'b0, 5'd5, 5'd6, 5'd7);
        #1;
        chk("lu.hazard_const", DW'(hazard_o),   DW'(1));
        chk("lu.pcw_const",    DW'(pc_write_o), DW'(0));
        cycle("lu.stall");
        chk("lu.bubble_valid", DW'(valid_o), DW'(0));
        cycle("lu.replay");
        chk("lu.add_valid",    DW'(valid_o), DW'(1));

        // Load to $0 never stalls
        drive(8'b11101000, 1'b0, 5'd9, 5'd0, 5'd0);
        cycle("lw0");
        drive(8'b10000101, 1'b0, 5'd0, 5'd0, 5'd4);
        cycle("lw0.use");
        // Non-matching registers
        drive(8'b11101000, 1'b0, 5'd9, 5'd5, 5'd0);
        cycle("lw5b");
        drive(8'b10000101, 1'b0, 5'd6, 5'd7, 5'd8);
        cycle("lw5b.nouse");

        // Plain flush: bubble without freeze
        drive(8'b10000101, 1'b1, 5'd1, 5'd2, 5'd3);
        #1;
        chk("flush.pcw_const", DW'(pc_write_o), DW'(1));
        cycle("flush");

        // Flush and hazard together: one bubble, freeze held
        drive(8'b11101000, 1'b0, 5'd9, 5'd4, 5'd0);
        cycle("lw4");
        drive(8'b10000101, 1'b1, 5'd1, 5'd4, 5'd3);
        cycle("flush_haz");
        drive(8'b10000101, 1'b0, 5'd1, 5'd4, 5'd3);
        cycle("flush_haz.after");

        // X scrub on a store bundle
        drive(8'b0x01100x, 1'b0, 5'd2, 5'd3, 5'd0);
        cycle("xscrub");
        chk("xscrub.const", DW'(ctrl_o), DW'(8'b00011000));
        chk("xscrub.noX",   DW'($isunknown(ctrl_o)), DW'(0));

`ifdef ID_EX_STALL_CNT_EN
        // Four separated hazards saturate a 2-bit counter
        for (int i = 0; i < 4; i++) begin
            drive(8'b11101000, 1'b0, 5'd9, 5'd10, 5'd0);
            cycle("cnt.lw");
            drive(8'b10000101, 1'b0, 5'd10, 5'd1, 5'd2);
            cycle("cnt.stall");
            chk("cnt.const", DW'(stall_cnt_o), DW'((i < 3) ? i + 1 : 3));
            drive(8'b10000101, 1'b0, 5'd10, 5'd1, 5'd2);
            cycle("cnt.replay");
        end
`endif

        // Reset asserted mid-stall clears outputs and drops the hazard at once
        drive(8'b11101000, 1'b0, 5'd9, 5'd11, 5'd0);
        cycle("lw11");
        drive(8'b10000101, 1'b0, 5'd11, 5'd1, 5'd2);
        #1;
        chk("mid.hazard_pre", DW'(hazard_o), DW'(1));
        #2;
        rst_i = 1'b0;
        model_reset();
        #1;
        chk("mid.hazard", DW'(hazard_o),   DW'(0));
        chk("mid.pcw",    DW'(pc_write_o), DW'(1));
        check_regs("mid");
        @(negedge clk);
        rst_i = 1'b1;

        // Random traffic with small register indices to provoke frequent hazards
        for (int i = 0; i < 300; i++) begin
            drive(CW'($urandom), ($urandom_range(0, 7) == 0), AW'($urandom_range(0, 3)),
                  AW'($urandom_range(0, 3)), AW'($urandom_range(0, 31)));
            if ($urandom_range(0, 1) == 1) ctrl_i[5] = 1'b1;
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
